data_ram_resp: RTL and testbench
================================

# data_ram_resp

Data-memory responder on the far end of the MEM stage's load/store port. Accepts one word-aligned request at a time from the MEM stage, inserts a parameterised number of wait states, performs a byte-lane write or a full-word read on an internal word array, and returns a single-cycle acknowledge. While a request is outstanding it raises a stall request to pipeline control. Misaligned and out-of-range accesses are terminated with an error acknowledge.

## Interface
- DEPTH_LOG2, 10: log2 of word count; the array holds 2^DEPTH_LOG2 32-bit words.
- WAIT_CYCLES, 1: wait states between capture and acknowledge, legal range 0..15.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset (rst==0 resets); one clock, asynchronous active-low reset.
- mem_ce_i  in  1  request valid; held high by MEM stage until it samples ack.
- mem_we_i  in  1  1 = write, 0 = read.
- mem_addr_i  in  32  byte address.
- mem_sel_i  in  4  byte-lane enables, big-endian: sel[3]→bits 31:24 (byte offset 0) … sel[0]→bits 7:0.
- mem_data_i  in  32  write data.
- mem_data_o  out  32  read data; valid in the ack cycle and held until the next ack.
- mem_ack_o  out  1  one-cycle completion pulse.
- mem_err_o  out  1  high with ack when the request was rejected.
- stallreq_o  out  1  combinational: mem_ce_i & ~mem_ack_o.

## Operation
- States: IDLE, WAIT, RESP. 4-bit wait counter.
- IDLE: if mem_ce_i, capture we/addr/sel/data and check for an error:
  - addr[1:0] != 0 → error.
  - addr[31:DEPTH_LOG2+2] != 0 → error.
  - sel == 0 on a write → error.
- IDLE transitions:
  - Error, or WAIT_CYCLES==0 → RESP.
  - Otherwise → WAIT, counter loaded with WAIT_CYCLES-1.
- WAIT: decrement the counter; at 0 → RESP. mem_ce_i is not re-sampled.
- RESP:
  - mem_ack_o=1, mem_err_o = error flag.
  - Valid write: update only the enabled byte lanes at the clock edge ending RESP.
  - Valid read: mem_data_o registered from the array on entry to RESP.
  - Error: mem_data_o=0, no array write.
  - Always → IDLE next cycle.
- In RESP, mem_ce_i still shows the completing request and is ignored. A new request is captured in IDLE, which gives a mandatory one-cycle bubble between back-to-back accesses.
- Reads ignore sel and return the full word.

## Timing
- Reset values: mem_data_o=0, mem_ack_o=0, mem_err_o=0, state=IDLE, counter=0. stallreq_o then follows mem_ce_i. Array contents are not reset.
- Latency from the first cycle ce is high in IDLE to ack: WAIT_CYCLES+1 cycles. Examples: WAIT_CYCLES=0 → ack in the next cycle; WAIT_CYCLES=3 → ack 4 cycles later. An error takes 1 cycle regardless of WAIT_CYCLES.
- Throughput: one access per WAIT_CYCLES+2 cycles.
- Reset asserted mid-access: abort immediately to IDLE with outputs at their reset values. A pending write is lost (no partial write). After release, a request still held on ce is captured afresh.
- mem_ce_i dropped during WAIT: the access still completes and acks. This is a requester protocol violation, but the responder does not hang.

## Structure
- Shared package/defines:
  - State encodings (IDLE/WAIT/RESP).
  - Byte-lane index constants.
  - Existing `RegBus`/`ZeroWord` widths.
- One natural sub-module: `byte_lane_ram`, a 2^DEPTH_LOG2 × 32 array with a 4-bit byte write enable and a registered read port. The FSM and address checking stay in data_ram_resp.

## Test plan
- Reset behaviour: hold rst=0 with ce=1 → ack=0, err=0, data_o=0, stallreq=1. Release rst → ack after WAIT_CYCLES+1 cycles.
- Write then read, WAIT_CYCLES=1: write addr 0x10, sel 4'b1111, data 0xDEADBEEF.
  - Ack arrives 2 cycles after capture, and stallreq is high for exactly those 2 cycles.
  - Read of 0x10 returns 0xDEADBEEF.
- Partial write: preload 0x11223344 at 0x20, then write sel 4'b0100 with data 0xAABBCCDD → read returns 0x11BB3344.
- Errors: read at 0x3 → ack+err after 1 cycle, data_o=0. Write at 0x1000 with DEPTH_LOG2=10 → err, and a subsequent read of 0x0 is unchanged.
- Back-to-back, WAIT_CYCLES=0: ce held for two consecutive requests → acks 2 cycles apart, one IDLE bubble between them, correct data for each.
- Reset mid-WAIT, WAIT_CYCLES=3: assert rst during a write in WAIT → no ack; a read afterwards returns the old contents.

Source files
------------

// File: rtl/data_ram_resp_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package data_ram_resp_pkg;

  localparam int REG_BUS   = 32;
  localparam logic [REG_BUS-1:0] ZERO_WORD = '0;
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  // Big-endian byte offset -> lane index (lane 3 holds bits 31:24)
  localparam int LANE_B0 = 3;
  localparam int LANE_B1 = 2;
  localparam int LANE_B2 = 1;
  localparam int LANE_B3 = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef logic [NUM_LANES-1:0][VEC_W-1:0] word_t;

  typedef struct packed {
    logic                 we;
    logic [NUM_LANES-1:0] sel;
    word_t                data;
  } req_t;

  function automatic logic req_err(logic we, logic [NUM_LANES-1:0] sel,
                                   logic [REG_BUS-1:0] addr, int unsigned depth_log2);
    logic [REG_BUS-1:0] hi;
    hi = addr >> (depth_log2 + 2);
    return (addr[1:0] != 2'b00) || (hi != ZERO_WORD) || (we && sel == '0);
  endfunction

endpackage

// File: rtl/data_ram_resp_if.sv
// Load/store port between the MEM stage (master) and the data-memory responder (slave).
interface data_ram_resp_if;
  import data_ram_resp_pkg::*;

  logic                 mem_ce_i;
  logic                 mem_we_i;
  logic [REG_BUS-1:0]   mem_addr_i;
  logic [NUM_LANES-1:0] mem_sel_i;
  logic [REG_BUS-1:0]   mem_data_i;
  logic [REG_BUS-1:0]   mem_data_o;
  logic                 mem_ack_o;
  logic                 mem_err_o;
  logic                 stallreq_o;

  modport master (
    output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    input  mem_data_o, mem_ack_o, mem_err_o, stallreq_o
  );

  modport slave (
    input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    output mem_data_o, mem_ack_o, mem_err_o, stallreq_o
  );
endinterface

// File: rtl/data_ram_resp_byte_lane_ram.sv
// Word array split into independent byte lanes: per-lane write enable, registered read port.
module byte_lane_ram
  import data_ram_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_LANES-1:0]  wr_be,
  input  logic [DEPTH_LOG2-1:0] wr_idx,
  input  word_t                 wr_data,
  input  logic                  rd_en,
  input  logic                  rd_clr,
  input  logic [DEPTH_LOG2-1:0] rd_idx,
  output word_t                 rd_data
);
  localparam int WORDS = 1 << DEPTH_LOG2;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [VEC_W-1:0] mem [WORDS];
    logic [VEC_W-1:0] q;

    // Array contents are deliberately not reset.
    always_ff @(posedge clk)
      if (wr_be[l]) mem[wr_idx] <= wr_data[l];

    always_ff @(posedge clk or negedge rst)
      if (!rst)        q <= '0;
      else if (rd_clr) q <= '0;
      else if (rd_en)  q <= mem[rd_idx];

    assign rd_data[l] = q;
  end
endmodule

// File: rtl/data_ram_resp.sv
// Data-memory responder: captures one request, inserts wait states, acks once with
// optional error; stall request held to pipeline control while a request is pending.
module data_ram_resp
  import data_ram_resp_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  data_ram_resp_if.slave  bus
);
  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  req_t                  req_q, req_live;
  logic [DEPTH_LOG2-1:0] idx_q, idx_live, rd_idx;
  logic                  err_q, err_live, err_cur, we_cur;
  logic                  capture, enter_resp, rd_en, rd_clr, ack;
  logic [NUM_LANES-1:0]  wr_be;
  word_t                 rd_data;

  assign req_live = '{we: bus.mem_we_i, sel: bus.mem_sel_i, data: bus.mem_data_i};
  assign idx_live = bus.mem_addr_i[DEPTH_LOG2+1:2];
  assign err_live = req_err(bus.mem_we_i, bus.mem_sel_i, bus.mem_addr_i, DEPTH_LOG2);
  assign capture  = (state_q == ST_IDLE) && bus.mem_ce_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE:
        if (bus.mem_ce_i) begin
          if (err_live || WAIT_CYCLES == 0) state_d = ST_RESP;
          else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      // ce is not looked at here: a dropped request still completes.
      ST_WAIT:
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        req_q <= req_live;
        idx_q <= idx_live;
        err_q <= err_live;
      end
    end

  // With zero wait states the request goes straight from the bus into RESP.
  assign we_cur     = capture ? bus.mem_we_i : req_q.we;
  assign err_cur    = capture ? err_live     : err_q;
  assign rd_idx     = capture ? idx_live     : idx_q;
  assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
  assign rd_en      = enter_resp && !we_cur && !err_cur;
  assign rd_clr     = enter_resp && err_cur;

  // Write commits on the edge that ends RESP; a reset in RESP cancels it.
  assign wr_be = (state_q == ST_RESP && req_q.we && !err_q) ? req_q.sel : '0;

  byte_lane_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_be   (wr_be),
    .wr_idx  (idx_q),
    .wr_data (req_q.data),
    .rd_en   (rd_en),
    .rd_clr  (rd_clr),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  assign ack            = (state_q == ST_RESP);
  assign bus.mem_ack_o  = ack;
  assign bus.mem_err_o  = ack && err_q;
  assign bus.mem_data_o = rd_data;
  assign bus.stallreq_o = bus.mem_ce_i && !ack;
endmodule

// File: tb/tb_data_ram_resp.sv
// Bench for data_ram_resp: three responders (WAIT_CYCLES 1/0/3) against a word-map model.
module tb_data_ram_resp;
  localparam int DL = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        ce [3];
  logic        we [3];
  logic [31:0] addr [3];
  logic [3:0]  sel [3];
  logic [31:0] din [3];
  logic [31:0] dout [3];
  logic        ack [3];
  logic        err [3];
  logic        stall [3];

  int total = 0;
  int bad   = 0;
  logic [31:0] mdl [int];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_ram_resp_if bus ();
    assign bus.mem_ce_i   = ce[g];
    assign bus.mem_we_i   = we[g];
    assign bus.mem_addr_i = addr[g];
    assign bus.mem_sel_i  = sel[g];
    assign bus.mem_data_i = din[g];
    assign dout[g]  = bus.mem_data_o;
    assign ack[g]   = bus.mem_ack_o;
    assign err[g]   = bus.mem_err_o;
    assign stall[g] = bus.stallreq_o;
    data_ram_resp #(.DEPTH_LOG2(DL), .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 0 : 3))) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  function automatic int wc(int d);
    return d == 0 ? 1 : (d == 1 ? 0 : 3);
  endfunction

  function automatic bit exp_err(logic w, logic [3:0] s, logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= (32'd1 << (DL + 2))) || (w && s == 4'h0);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  // One access; 'skip' edges pass before counting (back-to-back bubble), 'hold'
  // leaves ce high and returns in the ack cycle.
  task automatic access(int d, logic w, logic [31:0] a, logic [3:0] s, logic [31:0] wd,
                        bit hold, int skip, string tag);
    bit e, known;
    int lat, stalls, want, k;
    logic [31:0] rexp, nv;
    e      = exp_err(w, s, a);
    want   = e ? 1 : wc(d) + 1;
    k      = d * (1 << DL) + int'(a[DL+1:2]);
    known  = mdl.exists(k);
    rexp   = known ? mdl[k] : 'x;
    ce[d] = 1'b1; we[d] = w; addr[d] = a; sel[d] = s; din[d] = wd;
    if (skip > 0) repeat (skip) begin @(posedge clk); #1; end
    else #1;
    lat = 0; stalls = 0;
    for (int c = 0; c < 64; c++) begin
      if (ack[d]) break;
      if (stall[d]) stalls++;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(want));
    chk({tag, "_stalls"}, 32'(stalls), 32'(want));
    chk({tag, "_err"}, 32'(err[d]), 32'(e));
    chk({tag, "_stall_at_ack"}, 32'(stall[d]), 32'd0);
    if (!w && e) chk({tag, "_errdata"}, dout[d], 32'h0);
    else if (!w && known) chk({tag, "_rdata"}, dout[d], rexp);
    if (w && !e) begin
      nv = rexp;
      for (int b = 0; b < 4; b++) if (s[b]) nv[b*8 +: 8] = wd[b*8 +: 8];
      if (known || s == 4'hF) mdl[k] = nv;
    end
    if (!hold) begin
      ce[d] = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, v;
    int lat;
    for (int d = 0; d < 3; d++) begin
      ce[d] = 1'b1; we[d] = 1'b1; addr[d] = 32'h0; sel[d] = 4'hF; din[d] = 32'h0;
    end
    // Reset held with ce high
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_ack%0d", d), 32'(ack[d]), 32'd0);
      chk($sformatf("rst_err%0d", d), 32'(err[d]), 32'd0);
      chk($sformatf("rst_dout%0d", d), dout[d], 32'h0);
      chk($sformatf("rst_stall%0d", d), 32'(stall[d]), 32'd1);
    end
    ce[1] = 1'b0; ce[2] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    access(0, 1'b1, 32'h0, 4'hF, 32'h0BAD_F00D, 0, 0, "rel0");
    access(1, 1'b1, 32'h0, 4'hF, 32'h1111_0000, 0, 0, "pre1");
    access(2, 1'b1, 32'h0, 4'hF, 32'h2222_0000, 0, 0, "pre2");

    // Full write then read, one wait state
    access(0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 0, 0, "wr10");
    access(0, 1'b0, 32'h10, 4'h0, 32'h0, 0, 0, "rd10");
    chk("rd10_direct", dout[0], 32'hDEAD_BEEF);

    // Partial byte-lane write
    access(0, 1'b1, 32'h20, 4'hF, 32'h1122_3344, 0, 0, "wr20");
    access(0, 1'b1, 32'h20, 4'b0100, 32'hAABB_CCDD, 0, 0, "wr20p");
    access(0, 1'b0, 32'h20, 4'hF, 32'h0, 0, 0, "rd20");
    chk("rd20_direct", dout[0], 32'h11BB_3344);

    // Error terminations
    access(0, 1'b0, 32'h3, 4'hF, 32'h0, 0, 0, "rd_mis");
    access(0, 1'b1, 32'h1000, 4'hF, 32'hFFFF_FFFF, 0, 0, "wr_oob");
    access(0, 1'b1, 32'h0, 4'h0, 32'hFFFF_FFFF, 0, 0, "wr_sel0");
    access(0, 1'b0, 32'h0, 4'hF, 32'h0, 0, 0, "rd0_after");
    access(0, 1'b1, 32'hFFC, 4'hF, 32'hCAFE_0FFC, 0, 0, "wr_top");
    access(0, 1'b0, 32'hFFC, 4'h0, 32'h0, 0, 0, "rd_top");

    // Randomized traffic on a small window plus bad addresses
    for (int i = 0; i < 16; i++)
      access(0, 1'b1, 32'h100 + 32'(4 * i), 4'hF, $urandom, 0, 0, "win");
    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 9);
      a = 32'h100 + 32'(4 * $urandom_range(0, 15));
      if (r == 0) a = a | 32'($urandom_range(1, 3));
      else if (r == 1) a = a | (32'd1 << $urandom_range(DL + 2, 31));
      access(0, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom, 0, 0, "rnd");
    end

    // Back-to-back on the zero-wait responder
    access(1, 1'b1, 32'h40, 4'hF, 32'h0440_0440, 1, 0, "b2b_wr");
    access(1, 1'b0, 32'h40, 4'hF, 32'h0, 1, 1, "b2b_rd");
    access(1, 1'b0, 32'h0, 4'hF, 32'h0, 0, 1, "b2b_rd0");

    // Reset in the middle of a write's wait states
    access(2, 1'b1, 32'h80, 4'hF, 32'h0123_4567, 0, 0, "pre80");
    ce[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h80; sel[2] = 4'hF; din[2] = 32'h89AB_CDEF;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_ack", 32'(ack[2]), 32'd0);
    chk("midrst_err", 32'(err[2]), 32'd0);
    chk("midrst_dout", dout[2], 32'h0);
    chk("midrst_stall", 32'(stall[2]), 32'd1);
    ce[2] = 1'b0;
    v = 32'h0;
    repeat (3) begin @(posedge clk); #1; v = v | 32'(ack[2]); end
    chk("midrst_noack", v, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    access(2, 1'b0, 32'h80, 4'hF, 32'h0, 0, 0, "rd80_old");
    chk("rd80_direct", dout[2], 32'h0123_4567);

    // ce dropped during WAIT still completes
    ce[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h0; sel[2] = 4'hF;
    @(posedge clk); #1;
    ce[2] = 1'b0;
    lat = 1;
    for (int c = 0; c < 64 && !ack[2]; c++) begin @(posedge clk); #1; lat++; end
    chk("drop_lat", 32'(lat), 32'd4);
    chk("drop_data", dout[2], 32'h2222_0000);
    @(posedge clk); #1;
    chk("drop_noack", 32'(ack[2]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
